// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - fetch PC register with stall buffering of redirects/exceptions
module pc_fetch_stage #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_0008),
    parameter int              INC      = 4,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             exc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] pc,
    output logic             valid,
    output logic             pend,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             pend_exc;
    logic [WIDTH-1:0] pend_pc;
    logic [WIDTH-1:0] next_pc;

    // Select the PC for an advancing cycle; a dead slot re-presents the held PC
    always_comb begin
        next_pc = pc + WIDTH'(INC);
        if (exc) begin
            next_pc = EXC_VEC;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (pend) begin
            next_pc = pend_exc ? EXC_VEC : pend_pc;
        end else if (!valid) begin
            next_pc = pc;
        end
    end

    // State update: advance when enabled, otherwise hold and buffer requests
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc        <= RESET_PC;
            valid     <= 1'b0;
            pend      <= 1'b0;
            pend_exc  <= 1'b0;
            pend_pc   <= '0;
            stall_cnt <= '0;
        end else if (en) begin
            pc       <= next_pc;
            valid    <= ~flush;
            pend     <= 1'b0;
            // Clear the exception flag with the buffer so a later stall starts clean
            pend_exc <= 1'b0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end
            if (valid && !flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (exc) begin
                pend     <= 1'b1;
                pend_exc <= 1'b1;
            end else if (redirect_valid) begin
                pend    <= 1'b1;
                pend_pc <= redirect_pc;
            end
        end
    end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter WIDTH, default 32: width of every PC value.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_0008: PC loaded on exception.
REQ-004 Parameter INC, default 4: sequential PC increment.
REQ-005 Parameter CNT_W, default 16: stall counter width.
REQ-006 There is one clock. Reset is synchronous and active-low.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst  input  1  reset; synchronous, active-low (rst=0 resets).
REQ-009 en  input  1  advance enable; 0 = stall, hold PC and valid.
REQ-010 flush  input  1  kill current fetch slot.
REQ-011 exc  input  1  exception request.
REQ-012 redirect_valid  input  1  branch/jump redirect request.
REQ-013 redirect_pc  input  WIDTH  redirect target.
REQ-014 pc  output  WIDTH  current fetch PC (registered).
REQ-015 valid  output  1  pc holds a live fetch address (registered).
REQ-016 pend  output  1  a redirect or exception is buffered during a stall.
REQ-017 stall_cnt  output  CNT_W  saturating count of stalled live cycles.

Function
REQ-018 Internal state: pc, valid, pend, pend_exc, pend_pc, stall_cnt.
REQ-019 When en=1 and no flush, pc update priority is: exc -> EXC_VEC; redirect_valid -> redirect_pc; pend=1 -> (pend_exc ? EXC_VEC : pend_pc); valid=0 -> hold pc; otherwise pc+INC. In every case valid<=1 and pend<=0.
REQ-020 The first enabled cycle after reset presents RESET_PC with valid=1. The PC is not incremented on that cycle.
REQ-021 PC arithmetic is modulo 2^WIDTH. pc+INC from all-ones wraps to INC-1. No overflow flag is produced.
REQ-022 When en=0: pc and valid hold.
REQ-023 When en=0 and exc=1: pend<=1, pend_exc<=1.
REQ-024 When en=0, redirect_valid=1 and exc=0: pend<=1. pend_pc<=redirect_pc. pend_exc is unchanged.
REQ-025 While pend_exc=1, later redirects during the same stall update pend_pc but never clear pend_exc.
REQ-026 A later stalled redirect overwrites pend_pc (last target wins).
REQ-027 flush=1 sets valid<=0 on the next edge regardless of en. It has priority over REQ-019 and REQ-022 for valid only.
REQ-028 With flush=1 and en=1, pc follows REQ-019, but valid<=0. pend is consumed as normal.
REQ-029 With flush=1 and en=0, pc holds, and pend is captured per REQ-023/024.
REQ-030 After a flush bubble (valid=0), the next enabled cycle re-presents the held pc with valid=1 (REQ-019 "hold" case).
REQ-031 stall_cnt increments by 1 on each edge with en=0, valid=1 and flush=0.
REQ-032 stall_cnt saturates at 2^CNT_W-1 and never wraps.
REQ-033 All outputs are direct register outputs. Output latency from any input to its effect is exactly one edge.

Reset
REQ-034 On a rising edge with rst=0: pc<=RESET_PC, valid<=0, pend<=0, pend_exc<=0, pend_pc<=0, stall_cnt<=0.
REQ-035 Reset overrides en, flush, exc and redirect_valid on the same edge.
REQ-036 Reset asserted mid-stall with pend=1 discards the buffered request.
REQ-037 Outputs take their reset values after the first clocked reset edge. Pre-reset simulation values are don't-care.

Verification
REQ-038 Reset then en=1 for 4 edges -> pc sequence 0,4,8,12; valid=1 from the first edge.
REQ-039 pc=0x10, en=1, redirect_valid=1, redirect_pc=0x100, exc=1 same cycle -> pc=0x08, valid=1.
REQ-040 pc=0x20, en=0 for 3 cycles with redirect 0x200 then 0x300, then en=1 -> pend=1 during the stall; on resume pc=0x300, pend=0; stall_cnt=3.
REQ-041 pc=0x40, flush=1 with en=1 -> valid=0, pc=0x44. Next en=1 with no flush -> pc=0x44, valid=1.
REQ-042 WIDTH=8, pc=0xFC, en=1 -> pc=0x00. CNT_W=2 with 5 stalled live cycles -> stall_cnt=3.
REQ-043 en=0, exc=1 captured, then rst=0 -> pend=0, pc=RESET_PC, valid=0, stall_cnt=0.
